fifo_sync_flags: RTL

//  Parametrised single-clock FIFO, next generation of the team's FIFO block.

---
 rtl/fifo_sync_flags.sv | 100 ++++++++++
 1 files changed

// File: rtl/fifo_sync_flags.sv
// ============================================================================
// Module      : fifo_sync_flags
// Description : Single-clock FIFO with almost-full/almost-empty flags, optional
//               first-word-fall-through output, sticky error bits and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       CLEAR_N,
  input  logic [WIDTH-1:0]           DATA_IN,
  input  logic                       WRITE,
  input  logic                       READ,
  output logic [WIDTH-1:0]           DATA_OUT,
  output logic                       F_FULL_N,
  output logic                       F_EMPTY_N,
  output logic                       F_AFULL_N,
  output logic                       F_AEMPTY_N,
  output logic [$clog2(DEPTH):0]     USE_DW,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AF    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] C_AE    = (AW+1)'(AE_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_use_dw;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_rd_ok;
  logic             w_wr_ok;

  // Flags decode from the registered count only, so they lag the accepting edge.
  assign F_FULL_N   = (r_use_dw != C_DEPTH);
  assign F_EMPTY_N  = (r_use_dw != '0);
  assign F_AFULL_N  = !(r_use_dw >= C_AF);
  assign F_AEMPTY_N = !(r_use_dw <= C_AE);
  assign USE_DW     = r_use_dw;
  assign OVERFLOW   = r_overflow;
  assign UNDERFLOW  = r_underflow;

  // A write into a full FIFO is still absorbed when a read frees a slot that edge.
  assign w_rd_ok = READ & F_EMPTY_N;
  assign w_wr_ok = WRITE & (F_FULL_N | w_rd_ok);

  always_ff @(posedge CLOCK) begin
    if (RESET || !CLEAR_N) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_use_dw    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_use_dw <= r_use_dw + (AW+1)'(1);
        2'b01:   r_use_dw <= r_use_dw - (AW+1)'(1);
        default: r_use_dw <= r_use_dw;
      endcase
      if (WRITE && !w_wr_ok) r_overflow  <= 1'b1;
      if (READ && !F_EMPTY_N) r_underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLOCK) begin
    if (!RESET && CLEAR_N && w_wr_ok) r_mem[r_wr_ptr] <= DATA_IN;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign DATA_OUT = F_EMPTY_N ? r_mem[r_rd_ptr] : '0;
    end else begin : g_std
      logic [WIDTH-1:0] r_data_out;
      // Flush leaves the last read word visible; only reset zeroes it.
      always_ff @(posedge CLOCK) begin
        if (RESET) r_data_out <= '0;
        else if (CLEAR_N && w_rd_ok) r_data_out <= r_mem[r_rd_ptr];
      end
      assign DATA_OUT = r_data_out;
    end
  endgenerate

endmodule

`default_nettype wire
